// File: rtl/ws2812_pkg.sv
// ws2812_pkg: shared state type, legal pixel widths and ns-to-cycles helper
package ws2812_pkg;
  typedef enum logic [1:0] {IDLE, FILL, SEND, LATCH} state_t;
  localparam int BPP_RGB = 24;
  localparam int BPP_RGBW = 32;
  function automatic int ns_to_cycles(input int khz, input int ns);
    longint c;
    c = longint'(khz) * longint'(ns) / 1000000;
    return (c < 1) ? 1 : int'(c);
  endfunction
endpackage

// File: rtl/ws2812_strip_controller_if.sv
// ws2812_strip_controller_if: pixel stream valid/ready handshake
interface ws2812_strip_controller_if #(parameter int BITS_PER_PIXEL = 24);
  logic [BITS_PER_PIXEL-1:0] pixel_data;
  logic pixel_valid;
  logic pixel_ready;
  modport master (output pixel_data, pixel_valid, input pixel_ready);
  modport slave (input pixel_data, pixel_valid, output pixel_ready);
endinterface

// File: rtl/ws2812_bit_timer.sv
// ws2812_bit_timer: one return-to-zero bit waveform per start strobe
module ws2812_bit_timer #(
  parameter int T0H_C = 4,
  parameter int T1H_C = 8,
  parameter int BIT_C = 12
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic bit_val,
  output logic bit_end,
  output logic rz
);
  localparam int CW = $clog2(BIT_C + 1);
  logic [CW-1:0] cyc;
  logic run;
  logic bit_q;
  assign bit_end = run && cyc == CW'(BIT_C - 1);
  // cyc is the bit_cycle of the current output cycle; rz is registered against the next cycle's position
  always_ff @(posedge clk) begin
    if (rst) begin
      cyc <= '0;
      run <= 1'b0;
      bit_q <= 1'b0;
      rz <= 1'b0;
    end else if (start) begin
      cyc <= '0;
      run <= 1'b1;
      bit_q <= bit_val;
      rz <= 1'b1;
    end else if (run) begin
      cyc <= bit_end ? '0 : cyc + 1'b1;
      run <= !bit_end;
      rz <= !bit_end && (int'(cyc) + 1 < (bit_q ? T1H_C : T0H_C));
    end
  end
endmodule

// File: rtl/ws2812_strip_controller.sv
// ws2812_strip_controller: frame of pixels to WS2812 RZ serial line with latch and underrun abort
module ws2812_strip_controller
  import ws2812_pkg::*;
#(
  parameter int CLK_FREQ_KHZ = 10000,
  parameter int BITS_PER_PIXEL = 24,
  parameter int PIXEL_COUNT = 8,
  parameter int T0H_NS = 400,
  parameter int T1H_NS = 800,
  parameter int BIT_NS = 1250,
  parameter int LATCH_US = 50
) (
  input  logic clk,
  input  logic rst,
  input  logic frame_start,
  ws2812_strip_controller_if.slave pix,
  output logic busy,
  output logic frame_done,
  output logic underrun,
  output logic data_output
);
  localparam int T0H_C = ns_to_cycles(CLK_FREQ_KHZ, T0H_NS);
  localparam int T1H_C = ns_to_cycles(CLK_FREQ_KHZ, T1H_NS);
  localparam int BIT_C = ns_to_cycles(CLK_FREQ_KHZ, BIT_NS);
  localparam int LATCH_C = ns_to_cycles(CLK_FREQ_KHZ, LATCH_US * 1000);
  localparam int PCW = $clog2(PIXEL_COUNT + 1);
  localparam int BIW = $clog2(BITS_PER_PIXEL);
  localparam int LCW = $clog2(LATCH_C + 1);
  if (BITS_PER_PIXEL != BPP_RGB && BITS_PER_PIXEL != BPP_RGBW) begin : g_bad_bpp
    $error("BITS_PER_PIXEL must be 24 or 32");
  end
  if (PIXEL_COUNT < 1) begin : g_bad_count
    $error("PIXEL_COUNT must be at least 1");
  end
  if (T1H_C >= BIT_C) begin : g_bad_timing
    $error("T1H must be shorter than the bit period");
  end
  state_t state, state_n;
  logic [BITS_PER_PIXEL-1:0] shift_q, shift_n, hold_q, hold_n;
  logic hold_full, hold_full_n;
  logic [PCW-1:0] sent, sent_n, acc, acc_n;
  logic [BIW-1:0] bidx, bidx_n;
  logic [LCW-1:0] lcnt, lcnt_n;
  logic aborted, aborted_n;
  logic ready_q, ready_n;
  logic accept, start, bit_end, abort;
  assign accept = pix.pixel_valid && ready_q;
  assign pix.pixel_ready = ready_q;
  ws2812_bit_timer #(.T0H_C(T0H_C), .T1H_C(T1H_C), .BIT_C(BIT_C)) u_timer (
    .clk(clk),
    .rst(rst),
    .start(start),
    .bit_val(shift_n[BITS_PER_PIXEL-1]),
    .bit_end(bit_end),
    .rz(data_output)
  );
  // next-state: a pixel accepted in the end-of-pixel cycle lands in hold_n first, so it counts as present
  always_comb begin
    state_n = state;
    shift_n = shift_q;
    hold_n = hold_q;
    hold_full_n = hold_full;
    sent_n = sent;
    acc_n = (accept && acc != PCW'(PIXEL_COUNT)) ? acc + 1'b1 : acc;
    bidx_n = bidx;
    lcnt_n = lcnt;
    aborted_n = aborted;
    start = 1'b0;
    abort = 1'b0;
    case (state)
      IDLE: if (frame_start) begin
        state_n = FILL;
        sent_n = '0;
        acc_n = '0;
        hold_full_n = 1'b0;
        aborted_n = 1'b0;
      end
      FILL: if (accept) begin
        state_n = SEND;
        shift_n = pix.pixel_data;
        sent_n = sent + 1'b1;
        bidx_n = '0;
        start = 1'b1;
      end
      SEND: begin
        if (accept) begin
          hold_n = pix.pixel_data;
          hold_full_n = 1'b1;
        end
        if (bit_end) begin
          if (bidx != BIW'(BITS_PER_PIXEL - 1)) begin
            shift_n = shift_q << 1;
            bidx_n = bidx + 1'b1;
            start = 1'b1;
          end else if (sent == PCW'(PIXEL_COUNT)) begin
            state_n = LATCH;
            lcnt_n = '0;
          end else if (hold_full_n) begin
            shift_n = hold_n;
            hold_full_n = 1'b0;
            sent_n = sent + 1'b1;
            bidx_n = '0;
            start = 1'b1;
          end else begin
            state_n = LATCH;
            lcnt_n = '0;
            aborted_n = 1'b1;
            abort = 1'b1;
          end
        end
      end
      default: begin
        lcnt_n = lcnt + 1'b1;
        if (lcnt == LCW'(LATCH_C - 1)) state_n = IDLE;
      end
    endcase
    ready_n = (state_n == FILL || state_n == SEND) && !hold_full_n && acc_n < PCW'(PIXEL_COUNT);
  end
  // state, buffers, counters and registered status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      shift_q <= '0;
      hold_q <= '0;
      hold_full <= 1'b0;
      sent <= '0;
      acc <= '0;
      bidx <= '0;
      lcnt <= '0;
      aborted <= 1'b0;
      ready_q <= 1'b0;
      busy <= 1'b0;
      frame_done <= 1'b0;
      underrun <= 1'b0;
    end else begin
      state <= state_n;
      shift_q <= shift_n;
      hold_q <= hold_n;
      hold_full <= hold_full_n;
      sent <= sent_n;
      acc <= acc_n;
      bidx <= bidx_n;
      lcnt <= lcnt_n;
      aborted <= aborted_n;
      ready_q <= ready_n;
      busy <= state_n != IDLE;
      frame_done <= state_n == LATCH && lcnt_n == LCW'(LATCH_C - 1) && !aborted_n;
      underrun <= abort;
    end
  end
endmodule

// File: tb/tb_ws2812_strip_controller.sv
// tb_ws2812_strip_controller: directed checks of framing, RZ waveform shape, underrun and reset
module tb_ws2812_strip_controller;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic fs_a = 1'b0;
  logic fs_b = 1'b0;
  logic busy_a, done_a, urun_a, dout_a;
  logic busy_b, done_b, urun_b, dout_b;
  int n_vec = 0;
  int n_err = 0;
  int cyc_n = 0;
  int acc_tot = 0, rdy_tot = 0, urun_tot = 0, done_tot = 0;
  int rdy_snap = 0;
  logic [23:0] px_q [8];
  int gate_q [8];
  bit keep_v = 1'b0;
  always #5 clk = ~clk;
  ws2812_strip_controller_if #(.BITS_PER_PIXEL(24)) pa ();
  ws2812_strip_controller_if #(.BITS_PER_PIXEL(32)) pb ();
  ws2812_strip_controller dut_a (
    .clk(clk), .rst(rst), .frame_start(fs_a), .pix(pa),
    .busy(busy_a), .frame_done(done_a), .underrun(urun_a), .data_output(dout_a)
  );
  ws2812_strip_controller #(.BITS_PER_PIXEL(32), .PIXEL_COUNT(1)) dut_b (
    .clk(clk), .rst(rst), .frame_start(fs_b), .pix(pb),
    .busy(busy_b), .frame_done(done_b), .underrun(urun_b), .data_output(dout_b)
  );
  always @(posedge clk) cyc_n <= cyc_n + 1;
  always @(negedge clk) begin
    acc_tot <= acc_tot + ((pa.pixel_valid && pa.pixel_ready) ? 1 : 0);
    rdy_tot <= rdy_tot + (pa.pixel_ready ? 1 : 0);
    urun_tot <= urun_tot + (urun_a ? 1 : 0);
    done_tot <= done_tot + (done_a ? 1 : 0);
  end
  task automatic check(input string tag, input longint got, input longint exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic rx(input bit sel, input int bpp, output logic [31:0] val, output int bad);
    logic [11:0] s;
    int ones;
    logic b;
    val = '0;
    bad = 0;
    for (int k = 0; k < bpp; k++) begin
      ones = 0;
      for (int c = 0; c < 12; c++) begin
        s[c] = sel ? dout_b : dout_a;
        ones += s[c] ? 1 : 0;
        step;
      end
      b = ones == 8;
      for (int c = 0; c < 12; c++) if (s[c] != (c < (b ? 8 : 4))) bad++;
      val = {val[30:0], b};
    end
  endtask
  task automatic frame_a(input string tag, input int n_rx, output int t0);
    logic [31:0] v;
    int bad;
    int tot_bad;
    tot_bad = 0;
    fs_a = 1'b1;
    t0 = cyc_n;
    step;
    fs_a = 1'b0;
    check({tag, ".busy"}, busy_a, 1);
    check({tag, ".rdy"}, pa.pixel_ready, 1);
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          logic r;
          int w;
          if (gate_q[i] < 0) break;
          while (cyc_n - t0 < gate_q[i]) step;
          pa.pixel_data = px_q[i];
          pa.pixel_valid = 1'b1;
          w = 0;
          do begin
            r = pa.pixel_ready;
            step;
            w++;
          end while (!r && w < 3000);
          pa.pixel_valid = keep_v;
          check($sformatf("%s.acc%0d", tag, i), r, 1);
          if (!r) break;
        end
        rdy_snap = rdy_tot;
      end
      begin
        step;
        for (int i = 0; i < n_rx; i++) begin
          rx(1'b0, 24, v, bad);
          check($sformatf("%s.px%0d", tag, i), v, px_q[i]);
          tot_bad += bad;
        end
      end
    join
    check({tag, ".shape"}, tot_bad, 0);
  endtask
  task automatic wait_done(input bit sel, input string tag, input int t0, input int exp);
    int hi;
    int k;
    hi = 0;
    k = 0;
    while (!(sel ? done_b : done_a) && k < 700) begin
      hi += (sel ? dout_b : dout_a) ? 1 : 0;
      step;
      k++;
    end
    check({tag, ".done_at"}, cyc_n - t0, exp);
    check({tag, ".latch_hi"}, hi, 0);
    step;
    check({tag, ".idle"}, sel ? busy_b : busy_a, 0);
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int t0, a0, u0, d0, busy_c, hi, bad;
    logic r;
    logic [31:0] v;
    pa.pixel_valid = 1'b0;
    pa.pixel_data = '0;
    pb.pixel_valid = 1'b0;
    pb.pixel_data = '0;
    repeat (3) step;
    rst = 1'b0;
    step;
    check("rst.dout", dout_a, 0);
    check("rst.rdy", pa.pixel_ready, 0);
    check("rst.busy", busy_a, 0);
    check("rst.done", done_a, 0);
    check("rst.urun", urun_a, 0);
    check("rst.dout_b", dout_b, 0);
    fs_a = 1'b1;
    step;
    fs_a = 1'b0;
    pa.pixel_data = 24'hFF0000;
    pa.pixel_valid = 1'b1;
    step;
    pa.pixel_data = 24'h00FF00;
    check("midrst.pre_hi", dout_a, 1);
    rst = 1'b1;
    step;
    rst = 1'b0;
    pa.pixel_valid = 1'b0;
    check("midrst.dout", dout_a, 0);
    check("midrst.busy", busy_a, 0);
    check("midrst.rdy", pa.pixel_ready, 0);
    step;
    px_q = '{24'hFF0000, 24'h123456, 24'h00FF00, 24'h0000FF, 24'h800001, 24'hFFFFFF, 24'h000000, 24'hA5C3E7};
    gate_q = '{0, 0, 0, 0, 0, 0, 0, 0};
    u0 = urun_tot;
    d0 = done_tot;
    frame_a("main", 8, t0);
    wait_done(1'b0, "main", t0, 2805);
    check("main.urun", urun_tot - u0, 0);
    check("main.done_n", done_tot - d0, 1);
    px_q = '{24'hAAAAAA, 24'h555555, 24'hAAAAAA, 24'h555555, 24'hAAAAAA, 24'h555555, 24'hAAAAAA, 24'h555555};
    keep_v = 1'b1;
    a0 = acc_tot;
    frame_a("cont", 8, t0);
    wait_done(1'b0, "cont", t0, 2805);
    check("cont.acc_n", acc_tot - a0, 8);
    check("cont.rdy_after", rdy_tot - rdy_snap, 0);
    keep_v = 1'b0;
    pa.pixel_valid = 1'b0;
    step;
    px_q = '{24'h0F0F0F, 24'hF0F0F0, 24'h111111, 24'h222222, 24'h333333, 24'h444444, 24'h555555, 24'h666666};
    gate_q = '{0, 0, -1, 0, 0, 0, 0, 0};
    u0 = urun_tot;
    d0 = done_tot;
    frame_a("urun", 2, t0);
    check("urun.pulse", urun_a, 1);
    busy_c = 0;
    hi = 0;
    for (int k = 0; k < 600; k++) begin
      busy_c += busy_a ? 1 : 0;
      hi += dout_a ? 1 : 0;
      step;
    end
    check("urun.count", urun_tot - u0, 1);
    check("urun.no_done", done_tot - d0, 0);
    check("urun.latch_len", busy_c, 500);
    check("urun.latch_hi", hi, 0);
    px_q = '{24'h010203, 24'h804020, 24'hC0FFEE, 24'h7E7E7E, 24'h00000F, 24'hF00000, 24'h3C3C3C, 24'h999999};
    gate_q = '{0, 0, 577, 0, 0, 0, 0, 0};
    u0 = urun_tot;
    frame_a("late", 8, t0);
    wait_done(1'b0, "late", t0, 2805);
    check("late.urun", urun_tot - u0, 0);
    fs_b = 1'b1;
    t0 = cyc_n;
    step;
    fs_b = 1'b0;
    check("rgbw.rdy", pb.pixel_ready, 1);
    pb.pixel_data = 32'h00000001;
    pb.pixel_valid = 1'b1;
    r = pb.pixel_ready;
    step;
    pb.pixel_valid = 1'b0;
    check("rgbw.acc", r, 1);
    rx(1'b1, 32, v, bad);
    check("rgbw.px", v, 32'h00000001);
    check("rgbw.shape", bad, 0);
    check("rgbw.urun", urun_b, 0);
    wait_done(1'b1, "rgbw", t0, 885);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
